// File: rtl/spmv_sched_if.sv
// rtl/spmv_sched_if.sv - SpMV scheduler source, matrix-row, RAM and result bundle
interface spmv_sched_if #(
    parameter int MAT_RANK = 256,
    parameter int NNZ      = 4,
    parameter int AW       = $clog2(MAT_RANK)
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  err;

    logic [63:0]           src_data;
    logic                  src_vld;
    logic                  src_rdy;

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [63:0]           wr_data;

    logic [NNZ*AW-1:0]     row_col;
    logic [NNZ*64-1:0]     row_val;
    logic                  row_vld;
    logic                  row_rdy;

    logic                  rd_en;
    logic [NNZ*AW-1:0]     rd_addr;
    logic [NNZ*64-1:0]     rd_val;
    logic [AW-1:0]         rd_tag;

    logic                  res_vld;
    logic                  res_rdy;

    // The scheduler is the slave; the surrounding streams and datapath are the master.
    modport slave (
        input  start, src_data, src_vld, row_col, row_val, row_vld, res_vld, res_rdy,
        output busy, done, err, src_rdy, wr_en, wr_addr, wr_data, row_rdy,
               rd_en, rd_addr, rd_val, rd_tag
    );

    modport master (
        output start, src_data, src_vld, row_col, row_val, row_vld, res_vld, res_rdy,
        input  busy, done, err, src_rdy, wr_en, wr_addr, wr_data, row_rdy,
               rd_en, rd_addr, rd_val, rd_tag
    );
endinterface

// File: rtl/spmv_sched.sv
// rtl/spmv_sched.sv - SpMV frame scheduler: vector load, credited row issue, result drain
module spmv_sched #(
    parameter int MAT_RANK = 256,
    parameter int NNZ      = 4,
    parameter int MAX_OUT  = 4,
    parameter int AW       = $clog2(MAT_RANK)
) (
    input  logic        clk,
    input  logic        rst_n,
    spmv_sched_if.slave bus
);
    localparam int              OW        = $clog2(MAX_OUT + 1);
    localparam logic [AW-1:0]   LAST_WR   = AW'(MAT_RANK - 1);
    localparam logic [AW:0]     LAST_ROW  = (AW + 1)'(MAT_RANK - 1);
    localparam logic [AW:0]     RANK_C    = (AW + 1)'(MAT_RANK);
    localparam logic [OW-1:0]   MAX_OUT_C = OW'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   wr_cnt;
    logic [AW:0]     iss_cnt;
    logic [AW:0]     res_cnt;
    logic [OW-1:0]   out_cnt;

    logic src_hs;
    logic row_hs;
    logic res_hs;
    logic res_ok;
    logic frame_end;

    assign src_hs    = bus.src_vld & bus.src_rdy;
    assign row_hs    = bus.row_vld & bus.row_rdy;
    assign res_hs    = bus.res_vld & bus.res_rdy;
    // A result only counts while rows can be in flight and one is actually outstanding.
    assign res_ok    = res_hs && (state == ISSUE || state == DRAIN) && (out_cnt != '0);
    assign frame_end = (state == DRAIN) && res_ok && (res_cnt == LAST_ROW);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD;
            LOAD:    if (src_hs && wr_cnt == LAST_WR) state_nxt = ISSUE;
            ISSUE:   if (row_hs && iss_cnt == LAST_ROW) state_nxt = DRAIN;
            DRAIN:   if (frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state != IDLE);
        bus.src_rdy = (state == LOAD);
        bus.row_rdy = (state == ISSUE) && (out_cnt < MAX_OUT_C) && (iss_cnt < RANK_C);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            iss_cnt <= '0;
            res_cnt <= '0;
            out_cnt <= '0;
        end else if (state == IDLE && bus.start) begin
            wr_cnt  <= '0;
            iss_cnt <= '0;
            res_cnt <= '0;
            out_cnt <= '0;
        end else begin
            if (src_hs) wr_cnt  <= wr_cnt + 1'b1;
            if (row_hs) iss_cnt <= iss_cnt + 1'b1;
            if (res_ok) res_cnt <= res_cnt + 1'b1;
            // Issue and result in one cycle cancel; the credit gate keeps this from wrapping.
            if (row_hs && !res_ok) begin
                out_cnt <= out_cnt + 1'b1;
            end else if (res_ok && !row_hs) begin
                out_cnt <= out_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.rd_en   <= 1'b0;
            bus.rd_addr <= '0;
            bus.rd_val  <= '0;
            bus.rd_tag  <= '0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.wr_en <= src_hs;
            if (src_hs) begin
                bus.wr_addr <= wr_cnt;
                bus.wr_data <= bus.src_data;
            end
            bus.rd_en <= row_hs;
            if (row_hs) begin
                bus.rd_addr <= bus.row_col;
                bus.rd_val  <= bus.row_val;
                bus.rd_tag  <= iss_cnt[AW-1:0];
            end
            bus.done <= frame_end;
            if (res_hs && !res_ok) bus.err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spmv_sched.sv
// tb/tb_spmv_sched.sv - self-checking bench for spmv_sched with a frame-level reference model
module tb_spmv_sched;
    localparam int RANK  = 16;
    localparam int NNZ   = 4;
    localparam int MAXO  = 4;
    localparam int AW    = 4;
    localparam int IDLE  = 0;
    localparam int LOAD  = 1;
    localparam int ISSUE = 2;
    localparam int DRAIN = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spmv_sched_if #(.MAT_RANK(RANK), .NNZ(NNZ), .AW(AW)) bus ();

    spmv_sched #(.MAT_RANK(RANK), .NNZ(NNZ), .MAX_OUT(MAXO), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int                  ph, m_wr, m_iss, m_res, m_out;
    logic                m_err, m_done, m_wr_en, m_rd_en;
    logic [AW-1:0]       m_wr_addr, m_rd_tag;
    logic [63:0]         m_wr_data;
    logic [NNZ*AW-1:0]   m_rd_addr;
    logic [NNZ*64-1:0]   m_rd_val;

    bit       dp_on, seq_data, rnd_start;
    int       ready_cnt, src_idx;
    bit [7:0] pipe;
    int       wr_log[$];
    int       rd_log[$];

    typedef struct {
        logic row_vld;
        logic res_vld;
        logic res_rdy;
        logic exp_row_rdy;
        int   exp_out;
    } vec_t;
    vec_t vecs[13];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = IDLE; m_wr = 0; m_iss = 0; m_res = 0; m_out = 0;
        m_err = 0; m_done = 0; m_wr_en = 0; m_rd_en = 0;
        m_wr_addr = '0; m_rd_tag = '0; m_wr_data = '0; m_rd_addr = '0; m_rd_val = '0;
    endtask

    task automatic tick();
        bit s_hs, r_hs, res, res_good, exp_row_rdy;
        exp_row_rdy = (ph == ISSUE) && (m_out < MAXO) && (m_iss < RANK);
        chk1("src_rdy", bus.src_rdy, ph == LOAD);
        chk1("row_rdy", bus.row_rdy, exp_row_rdy);
        chk1("busy", bus.busy, ph != IDLE);
        s_hs     = bus.src_vld && (ph == LOAD);
        r_hs     = bus.row_vld && exp_row_rdy;
        res      = bus.res_vld && bus.res_rdy;
        res_good = res && (ph == ISSUE || ph == DRAIN) && (m_out > 0);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_wr_en = s_hs;
            if (s_hs) begin
                m_wr_addr = AW'(m_wr);
                m_wr_data = bus.src_data;
                src_idx++;
            end
            m_rd_en = r_hs;
            if (r_hs) begin
                m_rd_addr = bus.row_col;
                m_rd_val  = bus.row_val;
                m_rd_tag  = AW'(m_iss);
            end
            m_done = 0;
            if (res && !res_good) m_err = 1;
            if (ph == IDLE && bus.start) begin
                ph = LOAD; m_wr = 0; m_iss = 0; m_res = 0; m_out = 0;
            end
            if (s_hs) begin
                m_wr++;
                if (m_wr == RANK) ph = ISSUE;
            end
            if (r_hs) begin
                m_iss++;
                if (m_iss == RANK) ph = DRAIN;
            end
            m_out = m_out + int'(r_hs) - int'(res_good);
            if (res_good) begin
                m_res++;
                if (m_res == RANK) begin
                    ph = IDLE;
                    m_done = 1;
                end
            end
        end
        @(negedge clk);
        chk1("wr_en", bus.wr_en, m_wr_en);
        chkw("wr_addr", 256'(bus.wr_addr), 256'(m_wr_addr));
        chkw("wr_data", 256'(bus.wr_data), 256'(m_wr_data));
        chk1("rd_en", bus.rd_en, m_rd_en);
        chkw("rd_addr", 256'(bus.rd_addr), 256'(m_rd_addr));
        chkw("rd_val", bus.rd_val, m_rd_val);
        chkw("rd_tag", 256'(bus.rd_tag), 256'(m_rd_tag));
        chk1("done", bus.done, m_done);
        chk1("err", bus.err, m_err);
        if (bus.wr_en) wr_log.push_back(int'(bus.wr_addr));
        if (bus.rd_en) rd_log.push_back(int'(bus.rd_tag));
        // Datapath stand-in: each issued row yields one result three cycles after rd_en.
        if (dp_on) begin
            if (res && ready_cnt > 0) ready_cnt--;
            pipe = {pipe[6:0], bus.rd_en};
            if (pipe[2]) ready_cnt++;
        end
    endtask

    task automatic rand_row();
        bus.row_col = (NNZ*AW)'($urandom);
        for (int k = 0; k < NNZ*2; k++) bus.row_val[k*32 +: 32] = $urandom;
    endtask

    task automatic drive_cycle(input int p_src, input int p_row, input int p_rdy);
        bus.start    = rnd_start ? 1'($urandom_range(1)) : 1'b0;
        bus.src_vld  = ($urandom_range(99) < p_src);
        bus.src_data = seq_data ? 64'(src_idx) : {$urandom, $urandom};
        bus.row_vld  = ($urandom_range(99) < p_row);
        rand_row();
        bus.res_rdy  = ($urandom_range(99) < p_rdy);
        if (dp_on) bus.res_vld = (ready_cnt > 0);
        tick();
    endtask

    task automatic start_frame();
        wr_log.delete();
        rd_log.delete();
        src_idx     = 0;
        bus.start   = 1'b1;
        bus.src_vld = 1'b0;
        bus.row_vld = 1'b0;
        if (dp_on) bus.res_vld = (ready_cnt > 0);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic finish_frame(input int p_src, input int p_row, input int p_rdy);
        int n = 0;
        while (!bus.done && n < 3000) begin
            drive_cycle(p_src, p_row, p_rdy);
            n++;
        end
        chk1("frame_done", bus.done, 1'b1);
        bus.start   = 1'b0;
        bus.src_vld = 1'b0;
        bus.row_vld = 1'b0;
    endtask

    task automatic check_logs();
        chkw("wr_count", 256'(wr_log.size()), 256'(RANK));
        chkw("rd_count", 256'(rd_log.size()), 256'(RANK));
        foreach (wr_log[i]) chkw("wr_seq", 256'(wr_log[i]), 256'(i));
        foreach (rd_log[i]) chkw("rd_seq", 256'(rd_log[i]), 256'(i));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // {row_vld, res_vld, res_rdy} -> row_rdy before the edge, outstanding count after it
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 3};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 3};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 2};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.src_vld = 1'b0; bus.src_data = '0;
        bus.row_vld = 1'b0; bus.row_col = '0; bus.row_val = '0;
        bus.res_vld = 1'b0; bus.res_rdy = 1'b0;
        dp_on = 1; seq_data = 0; rnd_start = 0; ready_cnt = 0; pipe = '0; src_idx = 0;
        model_reset();
        repeat (2) @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();

        seq_data = 1;
        start_frame();
        finish_frame(100, 100, 100);
        chk1("nominal_err", bus.err, 1'b0);
        check_logs();
        seq_data = 0;

        start_frame();
        n = 0;
        while (ph != ISSUE && n < 100) begin
            drive_cycle(100, 0, 100);
            n++;
        end
        chk1("issue_entry_rdy", bus.row_rdy, 1'b1);
        dp_on = 0;
        bus.src_vld = 1'b0;
        for (int i = 0; i < 13; i++) begin
            bus.row_vld = vecs[i].row_vld;
            bus.res_vld = vecs[i].res_vld;
            bus.res_rdy = vecs[i].res_rdy;
            rand_row();
            chk1("tbl_row_rdy", bus.row_rdy, vecs[i].exp_row_rdy);
            tick();
            chkw("tbl_out", 256'(dut.out_cnt), 256'(vecs[i].exp_out));
        end
        dp_on = 1; ready_cnt = m_out; pipe = '0; bus.res_vld = 1'b0;
        finish_frame(100, 100, 100);
        check_logs();

        rnd_start = 1;
        start_frame();
        finish_frame(50, 50, 60);
        rnd_start = 0;
        chk1("bubbly_err", bus.err, 1'b0);
        check_logs();

        start_frame();
        bus.src_vld = 1'b1;
        tick();
        tick();
        bus.res_vld = 1'b1;
        bus.res_rdy = 1'b1;
        tick();
        bus.res_vld = 1'b0;
        chk1("err_in_load", bus.err, 1'b1);
        finish_frame(80, 80, 80);
        chk1("err_through_done", bus.err, 1'b1);
        check_logs();
        start_frame();
        finish_frame(100, 100, 100);
        chk1("err_sticky", bus.err, 1'b1);
        check_logs();

        start_frame();
        n = 0;
        while (m_iss < 8 && n < 400) begin
            drive_cycle(100, 100, 100);
            n++;
        end
        chk1("mid_issue_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        bus.row_vld = 1'b0;
        bus.res_vld = 1'b0;
        tick();
        rst_n = 1'b1;
        ready_cnt = 0;
        pipe = '0;
        chk1("post_reset_err", bus.err, 1'b0);
        start_frame();
        finish_frame(100, 100, 100);
        chk1("post_reset_frame_err", bus.err, 1'b0);
        check_logs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
